wt_schedule: RTL and testbench

WT_SCHEDULE -- requirements
Module: wt_schedule

---
 rtl/wt_schedule_if.sv | 22 ++
 rtl/wt_schedule.sv | 137 +++++++++++++
 tb/tb_wt_schedule.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wt_schedule_if.sv
// Stream bundle for the message schedule: padded words Mt in, schedule words Wt out.
// The schedule block sits on the slave modport; the feeder/hash-core side uses master.
interface wt_schedule_if;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/wt_schedule.sv
// SHA-2 message schedule: echoes the 16 input words, then expands W16..W(N-1) in place
// in a 16-entry circular buffer, one word per cycle through a registered output stage.
module wt_schedule (
    input  logic           axi_aclk,
    input  logic           reset,
    input  logic [1:0]     sha_type,
    wt_schedule_if.slave   bus
);
    typedef enum logic {LOAD, EXPAND} state_t;

    state_t      state_reg;
    logic [6:0]  t_reg;
    logic        mode_reg;
    logic        last_flag_reg;
    logic [63:0] data_reg;
    logic        valid_reg;
    logic        tlast_reg;

    logic [63:0] w_mem [16];

    logic        out_free;
    logic        in_fire;
    logic        in_mode;
    logic [63:0] in_word;
    logic [6:0]  last_round;
    logic [3:0]  t_lo;
    logic [3:0]  idx_m2;
    logic [3:0]  idx_m7;
    logic [3:0]  idx_m15;
    logic [31:0] wt32;
    logic [63:0] wt64;
    logic [63:0] expand_word;
    logic        w_we;
    logic [63:0] w_wdata;
    logic        unused_sha_bit;

    function automatic logic [31:0] sig0_32(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1_32(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [63:0] sig0_64(input logic [63:0] x);
        return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ {7'b0, x[63:7]};
    endfunction

    function automatic logic [63:0] sig1_64(input logic [63:0] x);
        return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ {6'b0, x[63:6]};
    endfunction

    assign unused_sha_bit = sha_type[0];

    assign out_free  = !valid_reg || bus.m_axis_tready;
    assign bus.s_axis_tready = !reset && (state_reg == LOAD) && out_free;
    assign in_fire   = bus.s_axis_tvalid && bus.s_axis_tready;

    // The first word of a block already obeys the incoming mode, before it is latched.
    assign in_mode   = (t_reg == 7'd0) ? sha_type[1] : mode_reg;
    assign in_word   = in_mode ? bus.s_axis_tdata : {32'h0, bus.s_axis_tdata[31:0]};
    assign last_round = mode_reg ? 7'd79 : 7'd63;

    // Circular-buffer taps: t-2, t-7, t-15 and t-16 (the slot about to be overwritten).
    assign t_lo    = t_reg[3:0];
    assign idx_m2  = t_lo - 4'd2;
    assign idx_m7  = t_lo - 4'd7;
    assign idx_m15 = t_lo + 4'd1;

    assign wt32 = sig1_32(w_mem[idx_m2][31:0]) + w_mem[idx_m7][31:0]
                + sig0_32(w_mem[idx_m15][31:0]) + w_mem[t_lo][31:0];
    assign wt64 = sig1_64(w_mem[idx_m2]) + w_mem[idx_m7]
                + sig0_64(w_mem[idx_m15]) + w_mem[t_lo];
    assign expand_word = mode_reg ? wt64 : {32'h0, wt32};

    assign w_we    = (state_reg == LOAD) ? in_fire : (out_free && !reset);
    assign w_wdata = (state_reg == LOAD) ? in_word : expand_word;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_w
            logic [63:0] w_reg;
            always_ff @(posedge axi_aclk) begin
                if (w_we && (t_lo == 4'(gi))) begin
                    w_reg <= w_wdata;
                end
            end
            assign w_mem[gi] = w_reg;
        end
    endgenerate

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            state_reg     <= LOAD;
            t_reg         <= 7'd0;
            mode_reg      <= 1'b0;
            last_flag_reg <= 1'b0;
            data_reg      <= 64'd0;
            valid_reg     <= 1'b0;
            tlast_reg     <= 1'b0;
        end else if (out_free) begin
            if (state_reg == LOAD) begin
                if (in_fire) begin
                    data_reg  <= in_word;
                    valid_reg <= 1'b1;
                    tlast_reg <= 1'b0;
                    t_reg     <= t_reg + 7'd1;
                    if (t_reg == 7'd0) begin
                        mode_reg      <= sha_type[1];
                        last_flag_reg <= bus.s_axis_tlast;
                    end else begin
                        last_flag_reg <= last_flag_reg | bus.s_axis_tlast;
                    end
                    if (t_reg == 7'd15) begin
                        state_reg <= EXPAND;
                    end
                end else begin
                    valid_reg <= 1'b0;
                    tlast_reg <= 1'b0;
                end
            end else begin
                data_reg  <= expand_word;
                valid_reg <= 1'b1;
                tlast_reg <= (t_reg == last_round) && last_flag_reg;
                if (t_reg == last_round) begin
                    t_reg     <= 7'd0;
                    state_reg <= LOAD;
                end else begin
                    t_reg <= t_reg + 7'd1;
                end
            end
        end
    end

    assign bus.m_axis_tdata  = data_reg;
    assign bus.m_axis_tvalid = valid_reg;
    assign bus.m_axis_tlast  = tlast_reg;
endmodule

// File: tb/tb_wt_schedule.sv
// Bench for wt_schedule: full-array schedule model feeding a scoreboard, directed
// known-answer blocks plus randomized blocks with random gaps and back-pressure.
module tb_wt_schedule;
    logic       axi_aclk = 1'b0;
    logic       reset;
    logic [1:0] sha_type;

    wt_schedule_if bus();

    wt_schedule dut (
        .axi_aclk (axi_aclk),
        .reset    (reset),
        .sha_type (sha_type),
        .bus      (bus)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    logic [63:0] cap_data [0:4095];
    logic        cap_last [0:4095];
    int          cap_cyc  [0:4095];
    int    beats_total = 0;
    int    beats_since_rst = 0;
    int    words_acc = 0;
    int    total_n = 0;
    int    cyc = 0;
    bit    cur_mode = 0;
    bit    rand_ready = 0;

    logic [63:0] abc256 [16];
    logic [63:0] abc512 [16];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic bail(input string what);
        checks++;
        errors++;
        $display("FAIL timeout %s: got no progress expected completion", what);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // Schedule functions written as textbook shift/rotate arithmetic.
    function automatic logic [31:0] r32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [63:0] r64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Whole schedule as a plain linear array W[0..N-1].
    function automatic void model_sched(input logic [63:0] m [16], input bit mode512,
                                        output logic [63:0] w [80]);
        logic [31:0] a;
        logic [31:0] s0;
        logic [31:0] s1;
        for (int i = 0; i < 80; i++) w[i] = 64'd0;
        for (int i = 0; i < 16; i++) w[i] = mode512 ? m[i] : {32'h0, m[i][31:0]};
        for (int i = 16; i < (mode512 ? 80 : 64); i++) begin
            if (mode512) begin
                w[i] = (r64(w[i-2], 19) ^ r64(w[i-2], 61) ^ (w[i-2] >> 6)) + w[i-7]
                     + (r64(w[i-15], 1) ^ r64(w[i-15], 8) ^ (w[i-15] >> 7)) + w[i-16];
            end else begin
                s1 = r32(w[i-2][31:0], 17) ^ r32(w[i-2][31:0], 19) ^ (w[i-2][31:0] >> 10);
                s0 = r32(w[i-15][31:0], 7) ^ r32(w[i-15][31:0], 18) ^ (w[i-15][31:0] >> 3);
                a  = s1 + w[i-7][31:0] + s0 + w[i-16][31:0];
                w[i] = {32'h0, a};
            end
        end
    endfunction

    task automatic model_push(input logic [63:0] m [16], input bit mode512, input bit blk_last);
        logic [63:0] w [80];
        beat_t b;
        int n;
        n = mode512 ? 80 : 64;
        model_sched(m, mode512, w);
        for (int i = 0; i < n; i++) begin
            b.data = w[i];
            b.last = (i == n - 1) && blk_last;
            exp_q.push_back(b);
        end
    endtask

    task automatic send_block(input logic [63:0] m [16], input bit mode512, input int last_idx,
                              input int toggle_at, input bit gaps);
        int guard;
        model_push(m, mode512, (last_idx >= 0) && (last_idx < 16));
        for (int i = 0; i < 16; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                bus.s_axis_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge axi_aclk);
                #1;
            end
            bus.s_axis_tdata  = m[i];
            bus.s_axis_tlast  = (i == last_idx);
            sha_type          = {(i >= toggle_at) ? ~mode512 : mode512, 1'($urandom_range(0, 1))};
            bus.s_axis_tvalid = 1'b1;
            guard = 0;
            forever begin
                @(negedge axi_aclk);
                if (bus.s_axis_tready) break;
                guard++;
                if (guard > 3000) bail("s_axis_tready");
            end
            @(posedge axi_aclk);
            #1;
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_beats(input int target);
        int guard;
        guard = 0;
        while (beats_total < target) begin
            @(negedge axi_aclk);
            guard++;
            if (guard > 8000) bail("m_axis beats");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge axi_aclk);
        #1;
    endtask

    task automatic do_reset(input int n);
        @(posedge axi_aclk);
        #1 reset = 1'b1;
        repeat (n) @(posedge axi_aclk);
        #1 reset = 1'b0;
    endtask

    // Downstream ready: always high, or a coin flip per cycle.
    initial begin
        bus.m_axis_tready = 1'b1;
        forever begin
            @(posedge axi_aclk);
            #1 bus.m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: scoreboard, hold-while-stalled, no input acceptance during expansion.
    initial begin
        bit          rst_prev;
        bit          prev_stall;
        logic [63:0] prev_data;
        logic        prev_last;
        beat_t       e;
        rst_prev   = 1'b0;
        prev_stall = 1'b0;
        prev_data  = 64'd0;
        prev_last  = 1'b0;
        forever begin
            @(negedge axi_aclk);
            cyc++;
            if (reset) begin
                exp_q.delete();
                words_acc       = 0;
                total_n         = 0;
                beats_since_rst = 0;
                prev_stall      = 1'b0;
                if (rst_prev) begin
                    check("reset_idle",
                          {bus.m_axis_tdata[31:0], 29'd0, bus.m_axis_tvalid, bus.m_axis_tlast, bus.s_axis_tready},
                          64'd0);
                    check("reset_data_hi", bus.m_axis_tdata, 64'd0);
                end
            end else begin
                if (prev_stall) begin
                    check("hold_valid", {63'd0, bus.m_axis_tvalid}, 64'd1);
                    check("hold_data", bus.m_axis_tdata, prev_data);
                    check("hold_last", {63'd0, bus.m_axis_tlast}, {63'd0, prev_last});
                end
                if (bus.s_axis_tready && (words_acc > 0) && (words_acc % 16 == 0)) begin
                    checks++;
                    if (beats_since_rst < total_n - 1) begin
                        errors++;
                        $display("FAIL tready_in_expand: got s_axis_tready=1 after %0d beats, required 0 until %0d beats",
                                 beats_since_rst, total_n - 1);
                    end
                end
                if (bus.s_axis_tvalid && bus.s_axis_tready) begin
                    if (words_acc % 16 == 0) cur_mode = sha_type[1];
                    words_acc++;
                    if (words_acc % 16 == 0) total_n += cur_mode ? 80 : 64;
                end
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %h, required no beat", bus.m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("wt_data", bus.m_axis_tdata, e.data);
                        check("wt_last", {63'd0, bus.m_axis_tlast}, {63'd0, e.last});
                    end
                    cap_data[beats_total] = bus.m_axis_tdata;
                    cap_last[beats_total] = bus.m_axis_tlast;
                    cap_cyc[beats_total]  = cyc;
                    beats_total++;
                    beats_since_rst++;
                end
                prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
                prev_data  = bus.m_axis_tdata;
                prev_last  = bus.m_axis_tlast;
            end
            rst_prev = reset;
        end
    end

    initial begin
        logic [63:0] w [80];
        logic [63:0] rw [16];
        logic [63:0] hi_or;
        int base;
        int base2;
        int lastcnt;
        int target;
        bit m512;
        int lidx;

        reset = 1'b1;
        sha_type = 2'b00;
        bus.s_axis_tdata  = 64'd0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            abc256[i] = 64'd0;
            abc512[i] = 64'd0;
        end
        abc256[0]  = 64'h0000000061626380;
        abc256[15] = 64'h18;
        abc512[0]  = 64'h6162638000000000;
        abc512[15] = 64'h18;

        // Pin the model to the published known answers.
        model_sched(abc256, 1'b0, w);
        check("model_w16_256", w[16], 64'h0000000061626380);
        check("model_w17_256", w[17], 64'h00000000000F0000);
        model_sched(abc512, 1'b1, w);
        check("model_w16_512", w[16], 64'h6162638000000000);
        check("model_w17_512", w[17], 64'h00030000000000C0);

        repeat (4) @(posedge axi_aclk);
        #1 reset = 1'b0;
        idle(2);

        // SHA-256 "abc"
        base = beats_total;
        send_block(abc256, 1'b0, 15, 99, 1'b0);
        wait_beats(base + 64);
        idle(4);
        $display("block abc256: %0d beats", beats_total - base);
        check("abc256_beats", 64'(beats_total - base), 64'd64);
        check("abc256_w0", cap_data[base], 64'h0000000061626380);
        check("abc256_w16", cap_data[base + 16], 64'h0000000061626380);
        check("abc256_w17", cap_data[base + 17], 64'h00000000000F0000);
        lastcnt = 0;
        for (int i = 0; i < 64; i++) lastcnt += int'(cap_last[base + i]);
        check("abc256_lastcnt", 64'(lastcnt), 64'd1);
        check("abc256_last64", {63'd0, cap_last[base + 63]}, 64'd1);

        // SHA-512 "abc"
        base = beats_total;
        send_block(abc512, 1'b1, 15, 99, 1'b0);
        wait_beats(base + 80);
        idle(4);
        $display("block abc512: %0d beats", beats_total - base);
        check("abc512_beats", 64'(beats_total - base), 64'd80);
        check("abc512_w16", cap_data[base + 16], 64'h6162638000000000);
        check("abc512_w17", cap_data[base + 17], 64'h00030000000000C0);
        check("abc512_last80", {63'd0, cap_last[base + 79]}, 64'd1);

        // "abc" under random back-pressure
        rand_ready = 1'b1;
        base = beats_total;
        send_block(abc256, 1'b0, 15, 99, 1'b0);
        wait_beats(base + 64);
        rand_ready = 1'b0;
        idle(4);
        $display("block abc256 stalled: %0d beats", beats_total - base);
        check("stall_beats", 64'(beats_total - base), 64'd64);
        check("stall_w17", cap_data[base + 17], 64'h00000000000F0000);

        // Two back-to-back blocks, tlast only on the second
        base = beats_total;
        send_block(abc256, 1'b0, -1, 99, 1'b0);
        send_block(abc256, 1'b0, 15, 99, 1'b0);
        wait_beats(base + 128);
        idle(4);
        $display("two blocks: %0d beats in %0d cycles", beats_total - base,
                 cap_cyc[base + 127] - cap_cyc[base] + 1);
        check("two_last64", {63'd0, cap_last[base + 63]}, 64'd0);
        check("two_last128", {63'd0, cap_last[base + 127]}, 64'd1);
        check("two_no_gap", 64'(cap_cyc[base + 127] - cap_cyc[base]), 64'd127);

        // Reset pulsed in the middle of expansion, then a clean block
        base = beats_total;
        send_block(abc256, 1'b0, 15, 99, 1'b0);
        wait_beats(base + 30);
        do_reset(3);
        idle(2);
        base2 = beats_total;
        send_block(abc256, 1'b0, 15, 99, 1'b0);
        wait_beats(base2 + 64);
        idle(4);
        $display("post-reset abc256: %0d beats", beats_total - base2);
        check("rst_beats", 64'(beats_total - base2), 64'd64);
        check("rst_w16", cap_data[base2 + 16], 64'h0000000061626380);
        check("rst_last", {63'd0, cap_last[base2 + 63]}, 64'd1);

        // sha_type flipped from word 5 on a SHA-256 block
        for (int i = 0; i < 16; i++) rw[i] = {$urandom, $urandom};
        base = beats_total;
        send_block(rw, 1'b0, 15, 5, 1'b0);
        wait_beats(base + 64);
        idle(4);
        hi_or = 64'd0;
        for (int i = 0; i < 64; i++) hi_or |= cap_data[base + i] & 64'hFFFFFFFF00000000;
        $display("toggled sha_type block: %0d beats", beats_total - base);
        check("toggle_beats", 64'(beats_total - base), 64'd64);
        check("toggle_upper_zero", hi_or, 64'd0);

        // tlast on an early word still marks the block
        base = beats_total;
        send_block(abc256, 1'b0, 3, 99, 1'b0);
        wait_beats(base + 64);
        idle(4);
        $display("early tlast block: %0d beats", beats_total - base);
        check("early_last", {63'd0, cap_last[base + 63]}, 64'd1);
        check("early_beats", 64'(beats_total - base), 64'd64);

        // Randomized blocks: random mode, tlast position, input gaps and back-pressure
        rand_ready = 1'b1;
        base = beats_total;
        target = base;
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 16; i++) rw[i] = {$urandom, $urandom};
            m512 = 1'($urandom_range(0, 1));
            lidx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
            target += m512 ? 80 : 64;
            $display("random block %0d: mode512=%0d tlast_word=%0d", b, m512, lidx);
            send_block(rw, m512, lidx, 99, 1'b1);
        end
        wait_beats(target);
        rand_ready = 1'b0;
        idle(6);
        check("random_beats", 64'(beats_total - base), 64'(target - base));
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
